// File: rtl/sc_scbc_pkg.sv
// Shared types and AXI constants for the single-beat
// command-to-AXI4 master bridge.
package sc_scbc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREQ,
    ST_WRSP,
    ST_RREQ,
    ST_RRSP,
    ST_RESP
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] CACHE_VAL   = 4'b0011;
  localparam logic [2:0] PROT_VAL    = 3'b000;
  localparam logic [7:0] LEN_SINGLE  = 8'd0;

endpackage

// File: rtl/sc_scbc_axim.sv
// Single-outstanding command port to AXI4 master bridge.
// Every non-constant output comes straight from a flop.
module sc_scbc_axim
  import sc_scbc_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_VAL     = 0
) (
  input  logic                      AXI_CLK,
  input  logic                      AXI_RESETN,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic                      CMD_WRITE,
  input  logic [AXI_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [31:0]               CMD_WDAT,
  input  logic [3:0]                CMD_WSTRB,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [31:0]               RSP_RDAT,
  output logic [1:0]                RSP_RESP,
  output logic [AXI_ID_WIDTH-1:0]   AXI_M_AWID,
  output logic [AXI_ADDR_WIDTH-1:0] AXI_M_AWADDR,
  output logic [7:0]                AXI_M_AWLEN,
  output logic [2:0]                AXI_M_AWSIZE,
  output logic [1:0]                AXI_M_AWBURST,
  output logic                      AXI_M_AWLOCK,
  output logic [3:0]                AXI_M_AWCACHE,
  output logic [2:0]                AXI_M_AWPROT,
  output logic                      AXI_M_AWVALID,
  input  logic                      AXI_M_AWREADY,
  output logic [31:0]               AXI_M_WDATA,
  output logic [3:0]                AXI_M_WSTRB,
  output logic                      AXI_M_WLAST,
  output logic                      AXI_M_WVALID,
  input  logic                      AXI_M_WREADY,
  input  logic [AXI_ID_WIDTH-1:0]   AXI_M_BID,
  input  logic [1:0]                AXI_M_BRESP,
  input  logic                      AXI_M_BVALID,
  output logic                      AXI_M_BREADY,
  output logic [AXI_ID_WIDTH-1:0]   AXI_M_ARID,
  output logic [AXI_ADDR_WIDTH-1:0] AXI_M_ARADDR,
  output logic [7:0]                AXI_M_ARLEN,
  output logic [2:0]                AXI_M_ARSIZE,
  output logic [1:0]                AXI_M_ARBURST,
  output logic                      AXI_M_ARLOCK,
  output logic [3:0]                AXI_M_ARCACHE,
  output logic [2:0]                AXI_M_ARPROT,
  output logic                      AXI_M_ARVALID,
  input  logic                      AXI_M_ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]   AXI_M_RID,
  input  logic [31:0]               AXI_M_RDATA,
  input  logic [1:0]                AXI_M_RRESP,
  input  logic                      AXI_M_RLAST,
  input  logic                      AXI_M_RVALID,
  output logic                      AXI_M_RREADY
);

  localparam logic [AXI_ID_WIDTH-1:0] ID_C =
    AXI_ID_WIDTH'(AXI_ID_VAL);

  state_t                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      b_ready_q, b_ready_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      r_ready_q, r_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [31:0]               rsp_rdat_q, rsp_rdat_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdat_q, wdat_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic                      aw_done, w_done;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdat_d  = rsp_rdat_q;
    rsp_resp_d  = rsp_resp_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    wstrb_d     = wstrb_q;
    aw_done     = !aw_valid_q || AXI_M_AWREADY;
    w_done      = !w_valid_q || AXI_M_WREADY;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (CMD_VALID && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = CMD_ADDR;
          wdat_d      = CMD_WDAT;
          wstrb_d     = CMD_WSTRB;
          if (CMD_WRITE) begin
            state_d    = ST_WREQ;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = ST_RREQ;
            ar_valid_d = 1'b1;
          end
        end
      end
      ST_WREQ: begin
        // AW and W retire independently; B waits for both
        if (AXI_M_AWREADY) aw_valid_d = 1'b0;
        if (AXI_M_WREADY)  w_valid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d   = ST_WRSP;
          b_ready_d = 1'b1;
        end
      end
      ST_WRSP: begin
        if (AXI_M_BVALID) begin
          state_d     = ST_RESP;
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdat_d  = '0;
          rsp_resp_d  = (AXI_M_BID != ID_C) ?
                        RESP_SLVERR : AXI_M_BRESP;
        end
      end
      ST_RREQ: begin
        if (AXI_M_ARREADY) begin
          state_d    = ST_RRSP;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      ST_RRSP: begin
        if (AXI_M_RVALID) begin
          state_d     = ST_RESP;
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdat_d  = AXI_M_RDATA;
          rsp_resp_d  = (AXI_M_RID != ID_C || !AXI_M_RLAST) ?
                        RESP_SLVERR : AXI_M_RRESP;
        end
      end
      ST_RESP: begin
        if (RSP_READY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdat_q  <= '0;
      rsp_resp_q  <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdat_q  <= rsp_rdat_d;
      rsp_resp_q  <= rsp_resp_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign CMD_READY     = cmd_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_RDAT      = rsp_rdat_q;
  assign RSP_RESP      = rsp_resp_q;
  assign AXI_M_AWID    = ID_C;
  assign AXI_M_AWADDR  = addr_q;
  assign AXI_M_AWLEN   = LEN_SINGLE;
  assign AXI_M_AWSIZE  = SIZE_4B;
  assign AXI_M_AWBURST = BURST_INCR;
  assign AXI_M_AWLOCK  = 1'b0;
  assign AXI_M_AWCACHE = CACHE_VAL;
  assign AXI_M_AWPROT  = PROT_VAL;
  assign AXI_M_AWVALID = aw_valid_q;
  assign AXI_M_WDATA   = wdat_q;
  assign AXI_M_WSTRB   = wstrb_q;
  assign AXI_M_WLAST   = 1'b1;
  assign AXI_M_WVALID  = w_valid_q;
  assign AXI_M_BREADY  = b_ready_q;
  assign AXI_M_ARID    = ID_C;
  assign AXI_M_ARADDR  = addr_q;
  assign AXI_M_ARLEN   = LEN_SINGLE;
  assign AXI_M_ARSIZE  = SIZE_4B;
  assign AXI_M_ARBURST = BURST_INCR;
  assign AXI_M_ARLOCK  = 1'b0;
  assign AXI_M_ARCACHE = CACHE_VAL;
  assign AXI_M_ARPROT  = PROT_VAL;
  assign AXI_M_ARVALID = ar_valid_q;
  assign AXI_M_RREADY  = r_ready_q;

endmodule

// File: tb/tb_sc_scbc_axim.sv
// Bench for sc_scbc_axim: directed scenarios plus random
// commands against a configurable AXI slave and a txn model.
module tb_sc_scbc_axim;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdat = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdat;
  logic [1:0]  rsp_resp;
  logic [0:0]  awid, arid;
  logic [31:0] awaddr, araddr, wdata, rdata = '0;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp = '0, rresp = '0;
  logic        awlock, arlock, wlast, rlast = 1'b1;
  logic [3:0]  awcache, arcache, wstrb;
  logic        awvalid, awready = 1'b0;
  logic        wvalid, wready = 1'b0;
  logic [0:0]  bid = '0, rid = '0;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sc_scbc_axim dut (
    .AXI_CLK(clk), .AXI_RESETN(rst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_WRITE(cmd_write), .CMD_ADDR(cmd_addr),
    .CMD_WDAT(cmd_wdat), .CMD_WSTRB(cmd_wstrb),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_RDAT(rsp_rdat), .RSP_RESP(rsp_resp),
    .AXI_M_AWID(awid), .AXI_M_AWADDR(awaddr),
    .AXI_M_AWLEN(awlen), .AXI_M_AWSIZE(awsize),
    .AXI_M_AWBURST(awburst), .AXI_M_AWLOCK(awlock),
    .AXI_M_AWCACHE(awcache), .AXI_M_AWPROT(awprot),
    .AXI_M_AWVALID(awvalid), .AXI_M_AWREADY(awready),
    .AXI_M_WDATA(wdata), .AXI_M_WSTRB(wstrb),
    .AXI_M_WLAST(wlast), .AXI_M_WVALID(wvalid),
    .AXI_M_WREADY(wready),
    .AXI_M_BID(bid), .AXI_M_BRESP(bresp),
    .AXI_M_BVALID(bvalid), .AXI_M_BREADY(bready),
    .AXI_M_ARID(arid), .AXI_M_ARADDR(araddr),
    .AXI_M_ARLEN(arlen), .AXI_M_ARSIZE(arsize),
    .AXI_M_ARBURST(arburst), .AXI_M_ARLOCK(arlock),
    .AXI_M_ARCACHE(arcache), .AXI_M_ARPROT(arprot),
    .AXI_M_ARVALID(arvalid), .AXI_M_ARREADY(arready),
    .AXI_M_RID(rid), .AXI_M_RDATA(rdata),
    .AXI_M_RRESP(rresp), .AXI_M_RLAST(rlast),
    .AXI_M_RVALID(rvalid), .AXI_M_RREADY(rready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // slave configuration
  int          c_aw_wait = 0, c_w_wait = 0, c_b_wait = 0;
  int          c_ar_wait = 0, c_r_wait = 0;
  logic [1:0]  c_bresp = 0, c_rresp = 0;
  logic [0:0]  c_bid = 0, c_rid = 0;
  logic [31:0] c_rdata = 0;
  logic        c_rlast = 1;

  // slave observations
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int          aw_hi = 0, w_hi = 0, ar_hi = 0;
  logic [31:0] o_awaddr = 0, o_wdata = 0, o_araddr = 0;
  logic [3:0]  o_wstrb = 0;

  // AXI slave: decides ready/valid at each falling edge
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_d, w_d, ar_d;
    bit p_awv, p_wv, p_arv, p_br, p_rr;
    logic [31:0] p_awa, p_wd, p_ara;
    logic [3:0]  p_ws;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0;
        arready = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_cnt = 0; r_cnt = 0;
        aw_d = 0; w_d = 0; ar_d = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
        p_br = 0; p_rr = 0;
        continue;
      end
      if (awready && p_awv) begin
        n_aw++; o_awaddr = p_awa; aw_d = 1;
        awready = 0; aw_cnt = 0;
      end
      if (wready && p_wv) begin
        n_w++; o_wdata = p_wd; o_wstrb = p_ws; w_d = 1;
        wready = 0; w_cnt = 0;
      end
      if (arready && p_arv) begin
        n_ar++; o_araddr = p_ara; ar_d = 1;
        arready = 0; ar_cnt = 0;
      end
      if (bvalid && p_br) begin n_b++; bvalid = 0; end
      if (rvalid && p_rr) begin n_r++; rvalid = 0; end
      if (awvalid) begin
        aw_hi++;
        if (aw_cnt >= c_aw_wait) awready = 1;
        else aw_cnt++;
      end
      if (wvalid) begin
        w_hi++;
        if (w_cnt >= c_w_wait) wready = 1;
        else w_cnt++;
      end
      if (arvalid) begin
        ar_hi++;
        if (ar_cnt >= c_ar_wait) arready = 1;
        else ar_cnt++;
      end
      if (aw_d && w_d && !bvalid) begin
        if (b_cnt >= c_b_wait) begin
          bvalid = 1; bresp = c_bresp; bid = c_bid;
          aw_d = 0; w_d = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (ar_d && !rvalid) begin
        if (r_cnt >= c_r_wait) begin
          rvalid = 1; rdata = c_rdata; rresp = c_rresp;
          rid = c_rid; rlast = c_rlast;
          ar_d = 0; r_cnt = 0;
        end else r_cnt++;
      end
      p_awv = awvalid; p_awa = awaddr;
      p_wv = wvalid; p_wd = wdata; p_ws = wstrb;
      p_arv = arvalid; p_ara = araddr;
      p_br = bready; p_rr = rready;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_obs();
    aw_hi = 0; w_hi = 0; ar_hi = 0;
  endtask

  // one full command; returns accept-to-RSP_VALID latency
  task automatic run_cmd(input bit wr,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         input logic [3:0] st,
                         input int hold,
                         output int lat);
    int k;
    int b0, aw0, w0, ar0, r0;
    logic [31:0] e_rdat;
    logic [1:0]  e_resp;
    b0 = n_b; aw0 = n_aw; w0 = n_w; ar0 = n_ar; r0 = n_r;
    if (wr) begin
      e_rdat = 0;
      e_resp = (c_bid != 0) ? 2'b10 : c_bresp;
    end else begin
      e_rdat = c_rdata;
      e_resp = (c_rid != 0 || !c_rlast) ? 2'b10 : c_rresp;
    end
    k = 0;
    while (!cmd_ready && k < 50) begin step(); k++; end
    chk("cmd_ready_timeout", k < 50, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr;
    cmd_wdat = wd; cmd_wstrb = st;
    step();
    lat = 1;
    // junk on the command port must be ignored while busy
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
    cmd_addr = $urandom; cmd_wdat = $urandom;
    cmd_wstrb = 4'($urandom);
    chk("cmd_ready_busy", cmd_ready, 0);
    while (!rsp_valid && lat < 200) begin step(); lat++; end
    chk("rsp_timeout", lat < 200, 1);
    chk("rsp_rdat", rsp_rdat, e_rdat);
    chk("rsp_resp", rsp_resp, e_resp);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 0;
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdat", rsp_rdat, e_rdat);
      chk("hold_resp", rsp_resp, e_resp);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1; cmd_valid = 0;
    step();
    rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("cmd_ready_next", cmd_ready, 1);
    if (wr) begin
      chk("n_aw", n_aw - aw0, 1);
      chk("n_w", n_w - w0, 1);
      chk("n_b", n_b - b0, 1);
      chk("awaddr", o_awaddr, addr);
      chk("wdata", o_wdata, wd);
      chk("wstrb", o_wstrb, st);
      chk("awaddr_hold", awaddr, addr);
    end else begin
      chk("n_ar", n_ar - ar0, 1);
      chk("n_r", n_r - r0, 1);
      chk("araddr", o_araddr, addr);
      chk("araddr_hold", araddr, addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat, k;
    bit wr;
    repeat (3) step();
    chk("rst_outs",
        {cmd_ready, rsp_valid, awvalid, wvalid, bready,
         arvalid, rready}, 0);
    chk("rst_rdat", rsp_rdat, 0);
    chk("rst_resp", rsp_resp, 0);
    chk("rst_addr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    rst_n = 1;
    step();
    chk("cmd_ready_first", cmd_ready, 1);
    chk("fixed_len", {awlen, arlen}, 0);
    chk("fixed_size", {awsize, arsize}, 6'b010010);
    chk("fixed_burst", {awburst, arburst}, 4'b0101);
    chk("fixed_cache", {awcache, arcache}, 8'h33);
    chk("fixed_misc", {awlock, arlock, awprot, arprot,
                       wlast, awid, arid}, 11'b00000000100);

    // zero-wait write
    clr_obs();
    run_cmd(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, lat);
    chk("wr_latency", lat, 3);
    chk("wr_aw_hi", aw_hi, 1);
    chk("wr_w_hi", w_hi, 1);

    // W accepted 4 cycles after AW
    c_w_wait = 4; clr_obs();
    run_cmd(1, 32'h1010, 32'hA5A55A5A, 4'h3, 0, lat);
    chk("wdly_aw_hi", aw_hi, 1);
    chk("wdly_w_hi", w_hi, 5);
    c_w_wait = 0;

    // read with 5 slave wait cycles
    c_r_wait = 5; c_rdata = 32'h12345678; clr_obs();
    run_cmd(0, 32'h2004, 0, 0, 0, lat);
    chk("rd_ar_hi", ar_hi, 1);
    chk("rd_latency", lat, 8);
    c_r_wait = 0;

    // zero-wait read latency
    c_rdata = 32'hCAFEF00D;
    run_cmd(0, 32'h3000, 0, 0, 0, lat);
    chk("rd0_latency", lat, 3);

    // wrong RID forces SLVERR
    c_rid = 1;
    run_cmd(0, 32'h2008, 0, 0, 0, lat);
    c_rid = 0;

    // response held off 6 cycles
    c_bresp = 2'b01;
    run_cmd(1, 32'h4000, 32'h0BADF00D, 4'h9, 6, lat);
    c_bresp = 0;

    // reset while waiting for B
    c_b_wait = 20;
    k = 0;
    while (!cmd_ready && k < 50) begin step(); k++; end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h5000;
    cmd_wdat = 32'h55; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 0;
    k = 0;
    while (!bready && k < 50) begin step(); k++; end
    chk("reach_wrsp", bready, 1);
    k = n_b;
    rst_n = 0;
    #1;
    chk("arst_outs",
        {cmd_ready, rsp_valid, awvalid, wvalid, bready,
         arvalid, rready}, 0);
    step();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    chk("no_b_after_rst", n_b - k, 0);
    c_b_wait = 0;
    run_cmd(1, 32'h6000, 32'h66, 4'h1, 0, lat);
    chk("post_rst_latency", lat, 3);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      c_aw_wait = $urandom_range(0, 3);
      c_w_wait  = $urandom_range(0, 3);
      c_b_wait  = $urandom_range(0, 3);
      c_ar_wait = $urandom_range(0, 3);
      c_r_wait  = $urandom_range(0, 3);
      c_bresp   = 2'($urandom);
      c_rresp   = 2'($urandom);
      c_rdata   = $urandom;
      c_bid     = 1'($urandom_range(0, 7) == 0);
      c_rid     = 1'($urandom_range(0, 7) == 0);
      c_rlast   = ($urandom_range(0, 7) != 0);
      run_cmd(wr, $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 2), lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
